// File: rtl/kgp_risc_pkg.sv
// Shared KGP-RISC definitions: halt encoding, instruction field positions and the
// fetch-stage state encoding. Used by the fetch unit, the decoder and the branch unit.
package kgp_risc_pkg;

  localparam int unsigned PC_W_DEF    = 10;
  localparam int unsigned INSTR_W_DEF = 32;

  localparam int unsigned OPC_MSB = 31;
  localparam int unsigned OPC_LSB = 29;
  localparam int unsigned FC_MSB  = 3;
  localparam int unsigned FC_LSB  = 0;

  localparam logic [2:0] OPC_HALT = 3'b111;
  localparam logic [3:0] FC_HALT  = 4'b1111;

  typedef enum logic [1:0] {
    ST_BUBBLE = 2'd0,
    ST_RUN    = 2'd1,
    ST_FLUSH  = 2'd2,
    ST_HALT   = 2'd3
  } fetch_state_e;

  // True when the opcode and function-code fields encode HALT.
  function automatic logic is_halt(input logic [2:0] opc, input logic [3:0] fc);
    return (opc == OPC_HALT) && (fc == FC_HALT);
  endfunction

endpackage

// File: rtl/inst_fetch_unit_if.sv
// Fetch-stage bus: redirect/stall inputs, BRAM address/data, and the decode-side
// outputs (instr, instr_valid, pc_out, npc_out, halted).
//   master : the fetch unit
//   slave  : BRAM, branch unit and decode as seen from outside the fetch unit
interface inst_fetch_unit_if #(
  parameter int unsigned PC_W    = 10,
  parameter int unsigned INSTR_W = 32
);
  logic               stall;
  logic               PCSrc;
  logic [PC_W-1:0]    eN;
  logic [PC_W-1:0]    imem_addr;
  logic [INSTR_W-1:0] imem_dout;
  logic [INSTR_W-1:0] instr;
  logic               instr_valid;
  logic [PC_W-1:0]    pc_out;
  logic [PC_W-1:0]    npc_out;
  logic               halted;

  modport master (
    input  stall, PCSrc, eN, imem_dout,
    output imem_addr, instr, instr_valid, pc_out, npc_out, halted
  );

  modport slave (
    output stall, PCSrc, eN, imem_dout,
    input  imem_addr, instr, instr_valid, pc_out, npc_out, halted
  );
endinterface

// File: rtl/inst_fetch_unit.sv
// PC register and fetch stage. Drives the word address of a 1-cycle-latency
// instruction BRAM and hands instr / pc_out / npc_out to decode, handling branch
// redirect (PCSrc/eN), downstream stall, wrong-path flush and program halt.
// Ports:
//   clk  : clock, all state updates on posedge
//   rst  : synchronous active-high reset
//   bus  : inst_fetch_unit_if.master (stall, PCSrc, eN, imem_addr, imem_dout,
//          instr, instr_valid, pc_out, npc_out, halted)
module inst_fetch_unit
  import kgp_risc_pkg::*;
#(
  parameter int unsigned     PC_W     = PC_W_DEF,
  parameter int unsigned     INSTR_W  = INSTR_W_DEF,
  parameter logic [PC_W-1:0] RESET_PC = '0
) (
  input  logic              clk,
  input  logic              rst,
  inst_fetch_unit_if.master bus
);

  fetch_state_e    state_q, state_d;
  logic [PC_W-1:0] pc_q, pc_d;
  logic [PC_W-1:0] pc_out_q, pc_out_d;

  logic redirect;
  logic halt_det;
  logic hold_addr;

  // Redirect is ignored once halted; halt is only recognised on a consumed RUN instr.
  always_comb begin
    redirect = bus.PCSrc && (state_q != ST_HALT);
    halt_det = (state_q == ST_RUN) && !bus.stall && !bus.PCSrc &&
               is_halt(bus.imem_dout[OPC_MSB:OPC_LSB], bus.imem_dout[FC_MSB:FC_LSB]);
    // Re-read pc_out_q whenever the presented instruction must be (re)delivered:
    // stalled RUN, frozen HALT, and FLUSH (which re-fetches the redirect target).
    hold_addr = (state_q == ST_HALT) || (state_q == ST_FLUSH) ||
                ((state_q == ST_RUN) && bus.stall);
  end

  // Next-state and PC update.
  always_comb begin
    state_d  = state_q;
    pc_d     = pc_q;
    pc_out_d = pc_out_q;
    unique case (state_q)
      ST_BUBBLE: begin
        if (redirect) begin
          pc_d     = bus.eN + PC_W'(1);
          pc_out_d = bus.eN;
          state_d  = ST_FLUSH;
        end else begin
          pc_out_d = pc_q;
          pc_d     = pc_q + PC_W'(1);
          state_d  = ST_RUN;
        end
      end
      ST_RUN: begin
        if (redirect) begin
          pc_d     = bus.eN + PC_W'(1);
          pc_out_d = bus.eN;
          state_d  = ST_FLUSH;
        end else if (halt_det) begin
          state_d = ST_HALT;
        end else if (!bus.stall) begin
          pc_out_d = pc_q;
          pc_d     = pc_q + PC_W'(1);
        end
      end
      ST_FLUSH: begin
        // Wrong-path data is dropped; the target was re-addressed this cycle so
        // RUN next cycle delivers mem[pc_out_q] with pc_q already at target+1.
        if (redirect) begin
          pc_d     = bus.eN + PC_W'(1);
          pc_out_d = bus.eN;
        end else begin
          state_d = ST_RUN;
        end
      end
      ST_HALT: begin
        state_d = ST_HALT;
      end
      default: begin
        state_d = ST_BUBBLE;
      end
    endcase
  end

  // State and PC registers.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q  <= ST_BUBBLE;
      pc_q     <= RESET_PC;
      pc_out_q <= RESET_PC;
    end else begin
      state_q  <= state_d;
      pc_q     <= pc_d;
      pc_out_q <= pc_out_d;
    end
  end

  // BRAM address and decode-side outputs.
  assign bus.imem_addr   = redirect ? bus.eN : (hold_addr ? pc_out_q : pc_q);
  assign bus.instr       = bus.imem_dout;
  assign bus.instr_valid = (state_q == ST_RUN);
  assign bus.halted      = (state_q == ST_HALT);
  assign bus.pc_out      = pc_out_q;
  assign bus.npc_out     = pc_out_q + PC_W'(1);

endmodule

// File: tb/tb_inst_fetch_unit.sv
// Bench for inst_fetch_unit: two DUTs (RESET_PC 0 and 3FE) each with a BRAM model
// mem[i] = 0x1000+i, mem[20] = halt word. Per-cycle vector tables plus a random-stall run.
module tb_inst_fetch_unit;
  import kgp_risc_pkg::*;

  localparam int unsigned PC_W    = 10;
  localparam int unsigned INSTR_W = 32;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic rst0, rst1;

  inst_fetch_unit_if #(.PC_W(PC_W), .INSTR_W(INSTR_W)) if0 ();
  inst_fetch_unit_if #(.PC_W(PC_W), .INSTR_W(INSTR_W)) if1 ();

  inst_fetch_unit #(.PC_W(PC_W), .INSTR_W(INSTR_W), .RESET_PC(10'h000)) dut0 (
    .clk(clk), .rst(rst0), .bus(if0.master));
  inst_fetch_unit #(.PC_W(PC_W), .INSTR_W(INSTR_W), .RESET_PC(10'h3FE)) dut1 (
    .clk(clk), .rst(rst1), .bus(if1.master));

  function automatic logic [31:0] mem_word(input logic [PC_W-1:0] a);
    if (a == 10'd20) return 32'hE000_000F;
    return 32'h0000_1000 + 32'(a);
  endfunction

  // Synchronous BRAM models, 1-cycle read latency.
  always @(posedge clk) begin
    if0.imem_dout <= mem_word(if0.imem_addr);
    if1.imem_dout <= mem_word(if1.imem_addr);
  end

  typedef struct {
    logic            rst;
    logic            stall;
    logic            pcsrc;
    logic [PC_W-1:0] en;
    bit              chk;
    logic            exp_valid;
    logic            exp_halted;
    logic [PC_W-1:0] exp_pc;
    bit              chk_addr;
    logic [PC_W-1:0] exp_addr;
  } vec_t;

  vec_t tab_a[$];
  vec_t tab_b[$];
  vec_t sb[$];
  logic [PC_W-1:0] exp_pcs[$];

  int n_tests = 0;
  int n_fail  = 0;

  function automatic vec_t mk(input logic r, input logic s, input logic p,
                              input logic [PC_W-1:0] e, input bit c, input logic v,
                              input logic h, input logic [PC_W-1:0] pc,
                              input bit ca, input logic [PC_W-1:0] a);
    vec_t t;
    t.rst = r; t.stall = s; t.pcsrc = p; t.en = e; t.chk = c;
    t.exp_valid = v; t.exp_halted = h; t.exp_pc = pc; t.chk_addr = ca; t.exp_addr = a;
    return t;
  endfunction

  task automatic check(input string name, input int idx, input logic [31:0] act,
                       input logic [31:0] exp);
    n_tests++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s[%0d]: got %h expected %h", name, idx, act, exp);
    end
  endtask

  // One cycle: drive after the edge, push expectation, compare at the falling edge.
  task automatic run_vec(input int d, input int idx, input vec_t v);
    vec_t e;
    logic            valid, halted;
    logic [PC_W-1:0] pc, npc, addr;
    logic [31:0]     instr;
    @(posedge clk);
    #1;
    if (d == 0) begin
      rst0 = v.rst; if0.stall = v.stall; if0.PCSrc = v.pcsrc; if0.eN = v.en;
    end else begin
      rst1 = v.rst; if1.stall = v.stall; if1.PCSrc = v.pcsrc; if1.eN = v.en;
    end
    sb.push_back(v);
    @(negedge clk);
    e = sb.pop_front();
    if (d == 0) begin
      valid = if0.instr_valid; halted = if0.halted; pc = if0.pc_out;
      npc = if0.npc_out; addr = if0.imem_addr; instr = if0.instr;
    end else begin
      valid = if1.instr_valid; halted = if1.halted; pc = if1.pc_out;
      npc = if1.npc_out; addr = if1.imem_addr; instr = if1.instr;
    end
    if (e.chk) begin
      check("instr_valid", idx, 32'(valid), 32'(e.exp_valid));
      check("halted", idx, 32'(halted), 32'(e.exp_halted));
      check("pc_out", idx, 32'(pc), 32'(e.exp_pc));
      if (e.exp_valid) begin
        check("instr", idx, instr, mem_word(e.exp_pc));
        check("npc_out", idx, 32'(npc), 32'(PC_W'(e.exp_pc + PC_W'(1))));
      end
    end
    if (e.chk_addr) check("imem_addr", idx, 32'(addr), 32'(e.exp_addr));
  endtask

  initial begin
    int delivered;
    rst0 = 1'b1; rst1 = 1'b1;
    if0.stall = 1'b0; if0.PCSrc = 1'b0; if0.eN = '0;
    if1.stall = 1'b0; if1.PCSrc = 1'b0; if1.eN = '0;

    //             rst  stl  pcs  eN    chk v    h    pc    ca addr
    tab_a.push_back(mk(1'b1,1'b0,1'b0,10'd0,  0,1'b0,1'b0,10'd0,  0,10'd0));
    tab_a.push_back(mk(1'b1,1'b0,1'b0,10'd0,  1,1'b0,1'b0,10'd0,  1,10'd0));
    tab_a.push_back(mk(1'b0,1'b0,1'b0,10'd0,  1,1'b0,1'b0,10'd0,  1,10'd0));
    tab_a.push_back(mk(1'b0,1'b0,1'b0,10'd0,  1,1'b1,1'b0,10'd0,  1,10'd1));
    tab_a.push_back(mk(1'b0,1'b0,1'b0,10'd0,  1,1'b1,1'b0,10'd1,  1,10'd2));
    tab_a.push_back(mk(1'b0,1'b0,1'b0,10'd0,  1,1'b1,1'b0,10'd2,  1,10'd3));
    tab_a.push_back(mk(1'b0,1'b0,1'b0,10'd0,  1,1'b1,1'b0,10'd3,  1,10'd4));
    tab_a.push_back(mk(1'b0,1'b0,1'b0,10'd0,  1,1'b1,1'b0,10'd4,  1,10'd5));
    // stall three cycles at pc 5
    tab_a.push_back(mk(1'b0,1'b1,1'b0,10'd0,  1,1'b1,1'b0,10'd5,  1,10'd5));
    tab_a.push_back(mk(1'b0,1'b1,1'b0,10'd0,  1,1'b1,1'b0,10'd5,  1,10'd5));
    tab_a.push_back(mk(1'b0,1'b1,1'b0,10'd0,  1,1'b1,1'b0,10'd5,  1,10'd5));
    tab_a.push_back(mk(1'b0,1'b0,1'b0,10'd0,  1,1'b1,1'b0,10'd5,  1,10'd6));
    tab_a.push_back(mk(1'b0,1'b0,1'b0,10'd0,  1,1'b1,1'b0,10'd6,  1,10'd7));
    // redirect to 150 at pc 7
    tab_a.push_back(mk(1'b0,1'b0,1'b1,10'd150,1,1'b1,1'b0,10'd7,  1,10'd150));
    tab_a.push_back(mk(1'b0,1'b0,1'b0,10'd0,  1,1'b0,1'b0,10'd150,0,10'd0));
    tab_a.push_back(mk(1'b0,1'b0,1'b0,10'd0,  1,1'b1,1'b0,10'd150,1,10'd151));
    tab_a.push_back(mk(1'b0,1'b0,1'b0,10'd0,  1,1'b1,1'b0,10'd151,1,10'd152));
    // redirect and stall together
    tab_a.push_back(mk(1'b0,1'b1,1'b1,10'd40, 1,1'b1,1'b0,10'd152,1,10'd40));
    tab_a.push_back(mk(1'b0,1'b0,1'b0,10'd0,  1,1'b0,1'b0,10'd40, 0,10'd0));
    tab_a.push_back(mk(1'b0,1'b0,1'b0,10'd0,  1,1'b1,1'b0,10'd40, 1,10'd41));
    // jump near the halt word
    tab_a.push_back(mk(1'b0,1'b0,1'b1,10'd17, 1,1'b1,1'b0,10'd41, 1,10'd17));
    tab_a.push_back(mk(1'b0,1'b0,1'b0,10'd0,  1,1'b0,1'b0,10'd17, 0,10'd0));
    tab_a.push_back(mk(1'b0,1'b0,1'b0,10'd0,  1,1'b1,1'b0,10'd17, 1,10'd18));
    tab_a.push_back(mk(1'b0,1'b0,1'b0,10'd0,  1,1'b1,1'b0,10'd18, 1,10'd19));
    tab_a.push_back(mk(1'b0,1'b0,1'b0,10'd0,  1,1'b1,1'b0,10'd19, 1,10'd20));
    tab_a.push_back(mk(1'b0,1'b0,1'b0,10'd0,  1,1'b1,1'b0,10'd20, 0,10'd0));
    tab_a.push_back(mk(1'b0,1'b0,1'b0,10'd0,  1,1'b0,1'b1,10'd20, 1,10'd20));
    tab_a.push_back(mk(1'b0,1'b0,1'b1,10'd99, 1,1'b0,1'b1,10'd20, 0,10'd0));
    tab_a.push_back(mk(1'b0,1'b0,1'b0,10'd0,  1,1'b0,1'b1,10'd20, 1,10'd20));
    tab_a.push_back(mk(1'b0,1'b1,1'b0,10'd0,  1,1'b0,1'b1,10'd20, 1,10'd20));
    // reset out of HALT
    tab_a.push_back(mk(1'b1,1'b0,1'b0,10'd0,  1,1'b0,1'b1,10'd20, 0,10'd0));
    tab_a.push_back(mk(1'b0,1'b0,1'b0,10'd0,  1,1'b0,1'b0,10'd0,  1,10'd0));
    tab_a.push_back(mk(1'b0,1'b0,1'b0,10'd0,  1,1'b1,1'b0,10'd0,  1,10'd1));
    tab_a.push_back(mk(1'b0,1'b0,1'b0,10'd0,  1,1'b1,1'b0,10'd1,  1,10'd2));

    // RESET_PC = 3FE: wrap, then reset while stalled
    tab_b.push_back(mk(1'b1,1'b0,1'b0,10'd0,  1,1'b0,1'b0,10'h3FE,1,10'h3FE));
    tab_b.push_back(mk(1'b0,1'b0,1'b0,10'd0,  1,1'b0,1'b0,10'h3FE,1,10'h3FE));
    tab_b.push_back(mk(1'b0,1'b0,1'b0,10'd0,  1,1'b1,1'b0,10'h3FE,1,10'h3FF));
    tab_b.push_back(mk(1'b0,1'b0,1'b0,10'd0,  1,1'b1,1'b0,10'h3FF,1,10'h000));
    tab_b.push_back(mk(1'b0,1'b0,1'b0,10'd0,  1,1'b1,1'b0,10'h000,1,10'h001));
    tab_b.push_back(mk(1'b0,1'b1,1'b0,10'd0,  1,1'b1,1'b0,10'h001,1,10'h001));
    tab_b.push_back(mk(1'b1,1'b1,1'b0,10'd0,  1,1'b1,1'b0,10'h001,0,10'd0));
    tab_b.push_back(mk(1'b0,1'b0,1'b0,10'd0,  1,1'b0,1'b0,10'h3FE,1,10'h3FE));
    tab_b.push_back(mk(1'b0,1'b0,1'b0,10'd0,  1,1'b1,1'b0,10'h3FE,1,10'h3FF));

    foreach (tab_a[i]) run_vec(0, i, tab_a[i]);

    // Random stalls on a fresh path at 200: each consumed instr pops the next PC.
    for (int k = 0; k < 100; k++) exp_pcs.push_back(PC_W'(200 + k));
    @(posedge clk); #1;
    if0.PCSrc = 1'b1; if0.eN = 10'd200; if0.stall = 1'b0;
    @(posedge clk); #1;
    if0.PCSrc = 1'b0;
    delivered = 0;
    for (int k = 0; k < 60; k++) begin
      @(posedge clk); #1;
      if0.stall = ($urandom_range(0, 2) == 0);
      @(negedge clk);
      if (if0.instr_valid) begin
        if (exp_pcs.size() == 0) begin
          check("rand_queue_empty", k, 32'd1, 32'd0);
        end else begin
          check("rand_pc", k, 32'(if0.pc_out), 32'(exp_pcs[0]));
          check("rand_instr", k, if0.instr, mem_word(exp_pcs[0]));
          if (!if0.stall) begin
            void'(exp_pcs.pop_front());
            delivered++;
          end
        end
      end else begin
        check("rand_valid", k, 32'(if0.instr_valid), 32'(k != 0));
      end
    end
    check("rand_delivered_min", 0, 32'(delivered >= 20), 32'd1);
    if0.stall = 1'b0;

    foreach (tab_b[i]) run_vec(1, i, tab_b[i]);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
